// File: rtl/issue_regread_stage_pkg.sv
// issue_regread_stage_pkg: shared types and machine configuration for the issue/regread stage
package issue_regread_stage_pkg;
  localparam int PHY_REG_NUM = 64;
  localparam int WB_WIDTH = 2;
  localparam int PREG_W = $clog2(PHY_REG_NUM);
  localparam int ROB_W = 5;
  typedef struct packed {
    logic [PREG_W-1:0] psrc0;
    logic [PREG_W-1:0] psrc1;
    logic psrc0_valid;
    logic psrc1_valid;
    logic [PREG_W-1:0] pdest;
    logic [ROB_W-1:0] rob_idx;
    logic position_bit;
  } issue_base_t;
  typedef struct packed {
    logic [3:0] fu_op;
    logic [1:0] sub_op;
  } option_code_t;
endpackage

// File: rtl/issue_regread_stage_rr_bank_buffer.sv
// rr_bank_buffer: 2-entry micro-op/operand FIFO with valid/ready handshake for one issue lane
module rr_bank_buffer
  import issue_regread_stage_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter type OPTION_CODE = option_code_t
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  enq_valid,
  output logic                  enq_ready,
  input  issue_base_t           enq_base,
  input  OPTION_CODE            enq_oc,
  input  logic [DATA_WIDTH-1:0] enq_src0,
  input  logic [DATA_WIDTH-1:0] enq_src1,
  output logic                  deq_valid,
  input  logic                  deq_ready,
  output issue_base_t           deq_base,
  output OPTION_CODE            deq_oc,
  output logic [DATA_WIDTH-1:0] deq_src0,
  output logic [DATA_WIDTH-1:0] deq_src1
);
  typedef struct packed {
    issue_base_t base;
    OPTION_CODE oc;
    logic [DATA_WIDTH-1:0] src0;
    logic [DATA_WIDTH-1:0] src1;
  } entry_t;
  entry_t mem [2];
  logic head, tail, enq, deq;
  logic [1:0] count;
  assign enq_ready = (count != 2'd2) & ~rst;
  assign deq_valid = count != 2'd0;
  assign enq = enq_valid & enq_ready;
  assign deq = deq_valid & deq_ready;
  assign {deq_base, deq_oc, deq_src0, deq_src1} = mem[head];
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      count <= '0;
      head <= 1'b0;
      tail <= 1'b0;
    end else begin
      count <= count + {1'b0, enq} - {1'b0, deq};
      head <= head ^ deq;
      tail <= tail ^ enq;
    end
  end
  always_ff @(posedge clk) if (enq) mem[tail] <= '{base: enq_base, oc: enq_oc, src0: enq_src0, src1: enq_src1};
endmodule

// File: rtl/issue_regread_stage.sv
// issue_regread_stage: per-bank regfile read with writeback bypass into a decoupling FU buffer
module issue_regread_stage
  import issue_regread_stage_pkg::*;
#(
  parameter int BANK_NUM = 2,
  parameter int DATA_WIDTH = 32,
  parameter type OPTION_CODE = option_code_t
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  flush_i,
  input  logic [BANK_NUM-1:0]                   issue_valid_i,
  output logic [BANK_NUM-1:0]                   issue_ready_o,
  input  issue_base_t [BANK_NUM-1:0]            issue_base_i,
  input  OPTION_CODE [BANK_NUM-1:0]             issue_oc_i,
  output logic [BANK_NUM-1:0][1:0][PREG_W-1:0]  rf_raddr_o,
  input  logic [BANK_NUM-1:0][1:0][DATA_WIDTH-1:0] rf_rdata_i,
  input  logic [WB_WIDTH-1:0]                   wb_i,
  input  logic [WB_WIDTH-1:0][PREG_W-1:0]       wb_pdest_i,
  input  logic [WB_WIDTH-1:0][DATA_WIDTH-1:0]   wb_data_i,
  output logic [BANK_NUM-1:0]                   exe_valid_o,
  input  logic [BANK_NUM-1:0]                   exe_ready_i,
  output issue_base_t [BANK_NUM-1:0]            exe_base_o,
  output OPTION_CODE [BANK_NUM-1:0]             exe_oc_o,
  output logic [BANK_NUM-1:0][DATA_WIDTH-1:0]   exe_src0_o,
  output logic [BANK_NUM-1:0][DATA_WIDTH-1:0]   exe_src1_o
);
  function automatic logic [DATA_WIDTH-1:0] resolve(input logic v, input logic [PREG_W-1:0] psrc,
                                                    input logic [DATA_WIDTH-1:0] rf);
    logic [DATA_WIDTH-1:0] r;
    r = rf;
    for (int k = WB_WIDTH - 1; k >= 0; k--) if (wb_i[k] && wb_pdest_i[k] == psrc) r = wb_data_i[k];
    return v ? r : '0;
  endfunction
  for (genvar b = 0; b < BANK_NUM; b++) begin : g_bank
    assign rf_raddr_o[b][0] = issue_base_i[b].psrc0;
    assign rf_raddr_o[b][1] = issue_base_i[b].psrc1;
    rr_bank_buffer #(.DATA_WIDTH(DATA_WIDTH), .OPTION_CODE(OPTION_CODE)) u_buf (
      .clk      (clk),
      .rst      (rst),
      .flush    (flush_i),
      .enq_valid(issue_valid_i[b]),
      .enq_ready(issue_ready_o[b]),
      .enq_base (issue_base_i[b]),
      .enq_oc   (issue_oc_i[b]),
      .enq_src0 (resolve(issue_base_i[b].psrc0_valid, issue_base_i[b].psrc0, rf_rdata_i[b][0])),
      .enq_src1 (resolve(issue_base_i[b].psrc1_valid, issue_base_i[b].psrc1, rf_rdata_i[b][1])),
      .deq_valid(exe_valid_o[b]),
      .deq_ready(exe_ready_i[b]),
      .deq_base (exe_base_o[b]),
      .deq_oc   (exe_oc_o[b]),
      .deq_src0 (exe_src0_o[b]),
      .deq_src1 (exe_src1_o[b])
    );
  end
endmodule

// File: tb/tb_issue_regread_stage.sv
// tb_issue_regread_stage: directed vector and sequence checks for issue_regread_stage
module tb_issue_regread_stage;
  import issue_regread_stage_pkg::*;
  localparam int BN = 2;
  localparam int DW = 32;
  logic clk = 1'b0;
  logic rst, flush_i;
  logic [BN-1:0] issue_valid_i, issue_ready_o, exe_valid_o, exe_ready_i;
  issue_base_t [BN-1:0] issue_base_i, exe_base_o;
  option_code_t [BN-1:0] issue_oc_i, exe_oc_o;
  logic [BN-1:0][1:0][PREG_W-1:0] rf_raddr_o;
  logic [BN-1:0][1:0][DW-1:0] rf_rdata_i;
  logic [WB_WIDTH-1:0] wb_i;
  logic [WB_WIDTH-1:0][PREG_W-1:0] wb_pdest_i;
  logic [WB_WIDTH-1:0][DW-1:0] wb_data_i;
  logic [BN-1:0][DW-1:0] exe_src0_o, exe_src1_o;
  int vectors = 0;
  int miscompares = 0;
  typedef struct {
    logic [5:0] p0, p1;
    logic v0, v1;
    logic [31:0] r0, r1;
    logic [1:0] wb;
    logic [5:0] pd0, pd1;
    logic [31:0] wd0, wd1, e0, e1;
  } vec_t;
  vec_t vt [6];
  issue_base_t exp_base [6];
  always #5 clk = ~clk;
  issue_regread_stage #(.BANK_NUM(BN), .DATA_WIDTH(DW), .OPTION_CODE(option_code_t)) dut (
    .clk(clk), .rst(rst), .flush_i(flush_i),
    .issue_valid_i(issue_valid_i), .issue_ready_o(issue_ready_o),
    .issue_base_i(issue_base_i), .issue_oc_i(issue_oc_i),
    .rf_raddr_o(rf_raddr_o), .rf_rdata_i(rf_rdata_i),
    .wb_i(wb_i), .wb_pdest_i(wb_pdest_i), .wb_data_i(wb_data_i),
    .exe_valid_o(exe_valid_o), .exe_ready_i(exe_ready_i),
    .exe_base_o(exe_base_o), .exe_oc_o(exe_oc_o),
    .exe_src0_o(exe_src0_o), .exe_src1_o(exe_src1_o)
  );
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask
  function automatic issue_base_t mk_base(input logic [5:0] p0, input logic v0, input logic [5:0] p1,
                                          input logic v1, input logic [5:0] pd);
    issue_base_t r;
    r = '0;
    r.psrc0 = p0;
    r.psrc0_valid = v0;
    r.psrc1 = p1;
    r.psrc1_valid = v1;
    r.pdest = pd;
    r.rob_idx = 5'(pd);
    r.position_bit = pd[0];
    return r;
  endfunction
  task automatic issue(input int b, input logic [5:0] p0, input logic [31:0] d0, input logic [5:0] tag);
    issue_valid_i[b] = 1'b1;
    issue_base_i[b] = mk_base(p0, 1'b1, 6'd0, 1'b0, tag);
    issue_oc_i[b] = option_code_t'(tag);
    rf_rdata_i[b][0] = d0;
    rf_rdata_i[b][1] = 32'h0;
  endtask
  initial begin
    rst = 1'b1; flush_i = 1'b0; issue_valid_i = '0; exe_ready_i = '1;
    issue_base_i = '0; issue_oc_i = '0; rf_rdata_i = '0;
    wb_i = '0; wb_pdest_i = '0; wb_data_i = '0;
    vt[0] = '{6'd5, 6'd7, 1'b1, 1'b1, 32'h11, 32'h22, 2'b00, 6'd0, 6'd0, 32'h0, 32'h0, 32'h11, 32'h22};
    vt[1] = '{6'd9, 6'd2, 1'b1, 1'b1, 32'h0, 32'h33, 2'b11, 6'd9, 6'd9, 32'hAB, 32'hCD, 32'hAB, 32'h33};
    vt[2] = '{6'd4, 6'd9, 1'b1, 1'b1, 32'h44, 32'h99, 2'b10, 6'd4, 6'd4, 32'h55, 32'h66, 32'h66, 32'h99};
    vt[3] = '{6'd1, 6'd3, 1'b1, 1'b0, 32'h10, 32'hFF, 2'b01, 6'd3, 6'd0, 32'h77, 32'h0, 32'h10, 32'h0};
    vt[4] = '{6'd12, 6'd13, 1'b1, 1'b1, 32'hC0, 32'hC1, 2'b11, 6'd13, 6'd12, 32'hA1, 32'hB2, 32'hB2, 32'hA1};
    vt[5] = '{6'd0, 6'd63, 1'b0, 1'b1, 32'hDEAD, 32'hFFFF_FFFF, 2'b00, 6'd0, 6'd0, 32'h0, 32'h0, 32'h0, 32'hFFFF_FFFF};
    repeat (2) @(negedge clk);
    check("rst_issue_ready", 64'(issue_ready_o), 64'h0);
    check("rst_exe_valid", 64'(exe_valid_o), 64'h0);
    rst = 1'b0;
    #1 check("post_rst_issue_ready", 64'(issue_ready_o), 64'h3);
    @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      exp_base[i] = mk_base(vt[i].p0, vt[i].v0, vt[i].p1, vt[i].v1, 6'(i + 20));
      issue_valid_i[0] = 1'b1;
      issue_base_i[0] = exp_base[i];
      issue_oc_i[0] = option_code_t'(i + 1);
      rf_rdata_i[0][0] = vt[i].r0;
      rf_rdata_i[0][1] = vt[i].r1;
      wb_i = vt[i].wb;
      wb_pdest_i[0] = vt[i].pd0;
      wb_pdest_i[1] = vt[i].pd1;
      wb_data_i[0] = vt[i].wd0;
      wb_data_i[1] = vt[i].wd1;
      #1;
      check($sformatf("v%0d_raddr0", i), 64'(rf_raddr_o[0][0]), 64'(vt[i].p0));
      check($sformatf("v%0d_raddr1", i), 64'(rf_raddr_o[0][1]), 64'(vt[i].p1));
      @(negedge clk);
      check($sformatf("v%0d_valid", i), 64'(exe_valid_o[0]), 64'h1);
      check($sformatf("v%0d_src0", i), 64'(exe_src0_o[0]), 64'(vt[i].e0));
      check($sformatf("v%0d_src1", i), 64'(exe_src1_o[0]), 64'(vt[i].e1));
      check($sformatf("v%0d_base", i), 64'(exe_base_o[0]), 64'(exp_base[i]));
      check($sformatf("v%0d_oc", i), 64'(exe_oc_o[0]), 64'(i + 1));
    end
    issue_valid_i = '0; wb_i = '0;
    @(negedge clk);
    check("drain_valid", 64'(exe_valid_o[0]), 64'h0);
    exe_ready_i[0] = 1'b0;
    issue(0, 6'd1, 32'hA0, 6'd1);
    #1 check("bp_ready0", 64'(issue_ready_o[0]), 64'h1);
    @(negedge clk);
    check("bp_valid_a", 64'(exe_valid_o[0]), 64'h1);
    check("bp_src_a", 64'(exe_src0_o[0]), 64'hA0);
    check("bp_ready1", 64'(issue_ready_o[0]), 64'h1);
    issue(0, 6'd2, 32'hB0, 6'd2);
    @(negedge clk);
    check("bp_full_ready", 64'(issue_ready_o[0]), 64'h0);
    check("bp_hold_a", 64'(exe_src0_o[0]), 64'hA0);
    issue(0, 6'd3, 32'hC0, 6'd3);
    @(negedge clk);
    check("bp_still_full", 64'(issue_ready_o[0]), 64'h0);
    check("bp_hold_a2", 64'(exe_src0_o[0]), 64'hA0);
    exe_ready_i[0] = 1'b1;
    @(negedge clk);
    check("bp_src_b", 64'(exe_src0_o[0]), 64'hB0);
    check("bp_ready_again", 64'(issue_ready_o[0]), 64'h1);
    @(negedge clk);
    check("bp_src_c", 64'(exe_src0_o[0]), 64'hC0);
    check("bp_valid_c", 64'(exe_valid_o[0]), 64'h1);
    issue_valid_i = '0;
    @(negedge clk);
    check("bp_empty", 64'(exe_valid_o[0]), 64'h0);
    exe_ready_i[0] = 1'b0;
    issue(0, 6'd4, 32'hD1, 6'd4);
    @(negedge clk);
    issue(0, 6'd5, 32'hD2, 6'd5);
    @(negedge clk);
    check("fl_full", 64'(issue_ready_o[0]), 64'h0);
    flush_i = 1'b1; exe_ready_i[0] = 1'b1;
    issue(0, 6'd6, 32'hD3, 6'd6);
    @(negedge clk);
    flush_i = 1'b0; issue_valid_i = '0;
    check("fl_valid", 64'(exe_valid_o[0]), 64'h0);
    check("fl_ready", 64'(issue_ready_o[0]), 64'h1);
    issue(0, 6'd7, 32'hD4, 6'd7);
    @(negedge clk);
    check("fl_after_valid", 64'(exe_valid_o[0]), 64'h1);
    check("fl_after_src", 64'(exe_src0_o[0]), 64'hD4);
    issue_valid_i = '0;
    @(negedge clk);
    exe_ready_i = 2'b01;
    for (int i = 0; i < 4; i++) begin
      issue(0, 6'(8 + i), 32'h50 + 32'(i), 6'(8 + i));
      issue(1, 6'(16 + i), 32'hE0 + 32'(i), 6'(16 + i));
      @(negedge clk);
      check($sformatf("ind%0d_b0_valid", i), 64'(exe_valid_o[0]), 64'h1);
      check($sformatf("ind%0d_b0_src", i), 64'(exe_src0_o[0]), 64'h50 + 64'(i));
      check($sformatf("ind%0d_b1_ready", i), 64'(issue_ready_o[1]), (i == 0) ? 64'h1 : 64'h0);
      check($sformatf("ind%0d_b1_src", i), 64'(exe_src0_o[1]), 64'hE0);
    end
    rst = 1'b1;
    #1 check("mid_rst_ready", 64'(issue_ready_o), 64'h0);
    @(negedge clk);
    check("mid_rst_valid", 64'(exe_valid_o), 64'h0);
    check("mid_rst_ready2", 64'(issue_ready_o), 64'h0);
    rst = 1'b0; issue_valid_i = '0;
    #1 check("after_mid_rst_ready", 64'(issue_ready_o), 64'h3);
    @(negedge clk);
    check("after_mid_rst_valid", 64'(exe_valid_o), 64'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
